// File: rtl/axi4_ram_responder.sv
// AXI4 memory-mapped slave backed by a true dual-port RAM. Independent read and
// write FSMs, one outstanding transaction per direction, IDs echoed unchanged.
module axi4_ram_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ID_W   = 4
) (
  input  logic                  s_axi_aclk,
  input  logic                  axi_rst,
  input  logic [ID_W-1:0]       s_axi_awid,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_W-1:0]       s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_W-1:0]       s_axi_arid,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_W-1:0]       s_axi_rid,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int         STRB_W      = DATA_W / 8;
  localparam int         LSB         = $clog2(STRB_W);
  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [2:0] FULL_SIZE   = 3'(LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != FULL_SIZE) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic fixed);
    return fixed ? idx : idx + IDX_W'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic              w_fixed_q, w_fixed_d, w_err_q, w_err_d;

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d, rd_idx;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic              r_fixed_q, r_fixed_d, r_err_q, r_err_d, rd_en;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_end, r_last_beat, mem_we;
  logic unused_addr;

  assign unused_addr = ^{s_axi_awaddr[ADDR_W-1:LSB+IDX_W], s_axi_awaddr[LSB-1:0],
                         s_axi_araddr[ADDR_W-1:LSB+IDX_W], s_axi_araddr[LSB-1:0]};

  // Outputs are forced idle during reset and masked to zero when not valid
  assign s_axi_awready = !axi_rst && (w_state_q == W_IDLE);
  assign s_axi_wready  = !axi_rst && (w_state_q == W_DATA);
  assign s_axi_bvalid  = !axi_rst && (w_state_q == W_RESP);
  assign s_axi_bid     = s_axi_bvalid ? w_id_q : '0;
  assign s_axi_bresp   = (s_axi_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign r_last_beat   = (r_cnt_q == r_len_q);
  assign s_axi_arready = !axi_rst && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = !axi_rst && (r_state_q == R_DATA);
  assign s_axi_rid     = s_axi_rvalid ? r_id_q : '0;
  assign s_axi_rdata   = (s_axi_rvalid && !r_err_q) ? rdata_q : '0;
  assign s_axi_rresp   = (s_axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rlast   = s_axi_rvalid && r_last_beat;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign b_hs   = s_axi_bvalid && s_axi_bready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_hs   = s_axi_rvalid && s_axi_rready;
  assign w_end  = (w_cnt_q == w_len_q) || s_axi_wlast;
  // During W_DATA w_err_q only reflects an unsupported size/burst
  assign mem_we = w_hs && !w_err_q;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_id_d    = s_axi_awid;
          w_idx_d   = s_axi_awaddr[LSB +: IDX_W];
          w_len_d   = s_axi_awlen;
          w_cnt_d   = 8'd0;
          w_fixed_d = (s_axi_awburst == BURST_FIXED);
          w_err_d   = unsupported(s_axi_awsize, s_axi_awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (w_end) begin
            w_err_d   = w_err_q || (s_axi_wlast != (w_cnt_q == w_len_q));
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            w_idx_d = next_idx(w_idx_q, w_fixed_q);
          end
        end
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    rd_en     = 1'b0;
    rd_idx    = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_id_d    = s_axi_arid;
          r_idx_d   = s_axi_araddr[LSB +: IDX_W];
          r_len_d   = s_axi_arlen;
          r_cnt_d   = 8'd0;
          r_fixed_d = (s_axi_arburst == BURST_FIXED);
          r_err_d   = unsupported(s_axi_arsize, s_axi_arburst);
          rd_en     = 1'b1;
          rd_idx    = s_axi_araddr[LSB +: IDX_W];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // Prefetch the next word only on a handshake so stalls hold rdata
        if (r_hs) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            r_idx_d = next_idx(r_idx_q, r_fixed_q);
            rd_en   = 1'b1;
            rd_idx  = next_idx(r_idx_q, r_fixed_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (axi_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    w_id_q    <= w_id_d;
    w_idx_q   <= w_idx_d;
    w_len_q   <= w_len_d;
    w_cnt_q   <= w_cnt_d;
    w_fixed_q <= w_fixed_d;
    w_err_q   <= w_err_d;
    r_id_q    <= r_id_d;
    r_idx_q   <= r_idx_d;
    r_len_q   <= r_len_d;
    r_cnt_q   <= r_cnt_d;
    r_fixed_q <= r_fixed_d;
    r_err_q   <= r_err_d;
  end

  // Write port; the read port below samples old contents on a same-word collision
  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rd_en) rdata_q <= mem_q[rd_idx];
  end

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder: bursts, strobes, backpressure, errors,
// aliasing and reset mid-burst, checked with immediate assertions.
module tb_axi4_ram_responder;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              axi_rst;
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid, s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid, s_axi_bready;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid, s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi4_ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .s_axi_aclk(clk), .axi_rst(axi_rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_count;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input int last_at);
    int t;
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    #1; t = 0;
    while (s_axi_awready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    check("awready", 32'(s_axi_awready), 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == last_at); s_axi_wvalid = 1'b1;
      #1; t = 0;
      while (s_axi_wready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
      check("wready", 32'(s_axi_wready), 1);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    #1; t = 0;
    while (s_axi_bvalid !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    check("bvalid", 32'(s_axi_bvalid), 1);
    b_resp = s_axi_bresp; b_id = s_axi_bid;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // stall_mode 1 drives rready as 1,0,0,1,0,0,...
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall_mode);
    int t, cyc;
    logic done, stalled, h_last;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    rd_count = 0; done = 1'b0; stalled = 1'b0; cyc = 0;
    h_data = '0; h_last = 1'b0; h_resp = '0;
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    #1; t = 0;
    while (s_axi_arready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    check("arready", 32'(s_axi_arready), 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready = (stall_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    #1;
    check("rvalid_first", 32'(s_axi_rvalid), 1);
    while (!done && cyc < 100) begin
      if (stalled) begin
        check("hold_data", s_axi_rdata, h_data);
        check("hold_last", 32'(s_axi_rlast), 32'(h_last));
        check("hold_resp", 32'(s_axi_rresp), 32'(h_resp));
      end
      if (s_axi_rvalid === 1'b1) begin
        if (s_axi_rready) begin
          if (rd_count < 16) begin
            rd_data[rd_count] = s_axi_rdata; rd_resp[rd_count] = s_axi_rresp;
            rd_last[rd_count] = s_axi_rlast; rd_id[rd_count] = s_axi_rid;
          end
          rd_count++;
          stalled = 1'b0;
          if (s_axi_rlast === 1'b1) done = 1'b1;
        end else begin
          stalled = 1'b1; h_data = s_axi_rdata; h_last = s_axi_rlast; h_resp = s_axi_rresp;
        end
      end
      @(negedge clk);
      cyc++;
      s_axi_rready = done ? 1'b0 : ((stall_mode == 0) ? 1'b1 : (cyc % 3 == 0));
      #1;
    end
    s_axi_rready = 1'b0;
    check("r_done", 32'(done), 1);
    check("rvalid_after", 32'(s_axi_rvalid), 0);
    check("arready_after", 32'(s_axi_arready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 0);
    check("rst_arready", 32'(s_axi_arready), 0);
    check("rst_wready", 32'(s_axi_wready), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rlast", 32'(s_axi_rlast), 0);
    check("rst_bresp", 32'(s_axi_bresp), 0);
    check("rst_rresp", 32'(s_axi_rresp), 0);
    check("rst_bid", 32'(s_axi_bid), 0);
    check("rst_rid", 32'(s_axi_rid), 0);
    @(negedge clk);
    axi_rst = 1'b0;
    #1;
    check("rel_awready", 32'(s_axi_awready), 1);
    check("rel_arready", 32'(s_axi_arready), 1);

    // INCR write then read-back
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    for (int k = 0; k < 16; k++) ws[k] = 4'hF;
    write_burst(4'd5, 32'h40, 8'd3, 3'd2, 2'b01, 4, 3);
    check("wr1_bresp", 32'(b_resp), 0);
    check("wr1_bid", 32'(b_id), 5);
    read_burst(4'd3, 32'h40, 8'd3, 3'd2, 2'b01, 0);
    check("rd1_count", rd_count, 4);
    check("rd1_rid", 32'(rd_id[0]), 3);
    for (int k = 0; k < 4; k++) begin
      check("rd1_data", rd_data[k], 32'h11111111 * (k + 1));
      check("rd1_last", 32'(rd_last[k]), 32'(k == 3));
      check("rd1_resp", 32'(rd_resp[k]), 0);
    end

    // Byte strobes
    wd[0] = 32'h0; ws[0] = 4'hF;
    write_burst(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    write_burst(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 1, 0);
    check("strb_bresp", 32'(b_resp), 0);
    ws[0] = 4'hF;
    read_burst(4'd2, 32'h80, 8'd0, 3'd2, 2'b01, 0);
    check("strb_count", rd_count, 1);
    check("strb_data", rd_data[0], 32'h00BB00DD);
    check("strb_last", 32'(rd_last[0]), 1);

    // Read backpressure over 8 beats
    for (int k = 0; k < 8; k++) wd[k] = 32'hA0000000 + k;
    write_burst(4'd7, 32'h100, 8'd7, 3'd2, 2'b01, 8, 7);
    check("bp_bresp", 32'(b_resp), 0);
    read_burst(4'd4, 32'h100, 8'd7, 3'd2, 2'b01, 1);
    check("bp_count", rd_count, 8);
    for (int k = 0; k < 8; k++) begin
      check("bp_data", rd_data[k], 32'hA0000000 + k);
      check("bp_last", 32'(rd_last[k]), 32'(k == 7));
    end

    // FIXED burst and address aliasing
    wd[0] = 32'hF0; wd[1] = 32'hF1; wd[2] = 32'hF2;
    write_burst(4'd2, 32'h10, 8'd2, 3'd2, 2'b01, 3, 2);
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    write_burst(4'd2, 32'h10, 8'd2, 3'd2, 2'b00, 3, 2);
    check("fix_bresp", 32'(b_resp), 0);
    read_burst(4'd2, 32'h10, 8'd2, 3'd2, 2'b01, 0);
    check("fix_w0", rd_data[0], 32'd3);
    check("fix_w1", rd_data[1], 32'hF1);
    check("fix_w2", rd_data[2], 32'hF2);
    wd[0] = 32'hCAFEF00D;
    write_burst(4'd6, 32'h1000, 8'd0, 3'd2, 2'b01, 1, 0);
    read_burst(4'd6, 32'h0, 8'd0, 3'd2, 2'b01, 0);
    check("alias_data", rd_data[0], 32'hCAFEF00D);

    // Error responses
    wd[0] = 32'h12345678;
    write_burst(4'd3, 32'h80, 8'd0, 3'd1, 2'b01, 1, 0);
    check("size_bresp", 32'(b_resp), 2);
    check("size_bid", 32'(b_id), 3);
    read_burst(4'd3, 32'h80, 8'd0, 3'd2, 2'b01, 0);
    check("size_mem", rd_data[0], 32'h00BB00DD);
    wd[0] = 32'h55555555; wd[1] = 32'h66666666;
    write_burst(4'd4, 32'h200, 8'd3, 3'd2, 2'b01, 2, 1);
    check("early_bresp", 32'(b_resp), 2);
    check("early_bid", 32'(b_id), 4);
    read_burst(4'd9, 32'h40, 8'd1, 3'd2, 2'b10, 0);
    check("wrap_count", rd_count, 2);
    for (int k = 0; k < 2; k++) begin
      check("wrap_resp", 32'(rd_resp[k]), 2);
      check("wrap_data", rd_data[k], 0);
      check("wrap_last", 32'(rd_last[k]), 32'(k == 1));
    end

    // Reset during beat 2 of a len=7 read
    @(negedge clk);
    s_axi_arid = 4'd1; s_axi_araddr = 32'h40; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    #1;
    check("mid_arready", 32'(s_axi_arready), 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    check("mid_beat0", s_axi_rdata, 32'h11111111);
    @(negedge clk);
    #1;
    check("mid_beat1", s_axi_rdata, 32'h22222222);
    @(negedge clk);
    axi_rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rvalid_rst", 32'(s_axi_rvalid), 0);
    check("mid_arready_rst", 32'(s_axi_arready), 0);
    @(negedge clk);
    axi_rst = 1'b0; s_axi_rready = 1'b0;
    #1;
    check("mid_arready_rel", 32'(s_axi_arready), 1);
    check("mid_rvalid_rel", 32'(s_axi_rvalid), 0);
    check("mid_awready_rel", 32'(s_axi_awready), 1);
    read_burst(4'd2, 32'h40, 8'd3, 3'd2, 2'b01, 0);
    check("post_count", rd_count, 4);
    for (int k = 0; k < 4; k++) check("post_data", rd_data[k], 32'h11111111 * (k + 1));
    read_burst(4'd2, 32'h11C, 8'd0, 3'd2, 2'b01, 0);
    check("post_keep", rd_data[0], 32'hA0000007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_ram_responder.md
Name: axi4_ram_responder

Overview:
- AXI4 memory-mapped slave backed by an internal RAM array. It answers the DMA's master port: MM2S read bursts and S2MM write bursts.
- Sits on the DMA's m_axi port in simulation and loopback builds. It lets the mm2s/s2mm paths run without an external memory controller.
- Read and write channels run independent FSMs over a true dual-port array.

Parameters:
- DATA_W, 32, data bus width in bits; power of two, 32..512.
- ADDR_W, 32, AXI address width.
- DEPTH, 1024, number of DATA_W words; power of two.
- ID_W, 4, AXI ID width; IDs are echoed unchanged.

Ports:
- s_axi_aclk  in  1  sole clock.
- axi_rst  in  1  synchronous active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address.
- s_axi_awvalid  in  1 ; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1 ; s_axi_wready  out  1.
- s_axi_bid/bresp/bvalid  out  ID_W/2/1 ; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2 ; s_axi_arvalid  in  1 ; s_axi_arready  out  1.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1 ; s_axi_rready  in  1.

Behaviour:
- Clock and reset: one clock, s_axi_aclk. Reset is synchronous and active-high on axi_rst.
- Reset values: while axi_rst=1, all ready/valid outputs are 0; bresp, rresp, rlast, rdata, bid and rid are 0. The first cycle after release has awready=arready=1.
- Reset does not clear RAM contents.
- Word index: addr[log2(DATA_W/8) +: log2(DEPTH)]. Upper address bits are ignored, so addresses alias modulo DEPTH.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id, index, len, burst and size; clear the beat counter; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb at the current index.
  - Index update: INCR adds 1 (wraps modulo DEPTH); FIXED keeps the index.
  - The burst ends on the beat where counter==len, whatever wlast says. A wlast seen earlier also ends it.
  - W_RESP: bvalid=1 with bid set to the latched id. Hold until bready, then return to W_IDLE; awready is back to 1 on the next cycle.
- bresp rules:
  - OKAY in the normal case.
  - SLVERR if the latched size != log2(DATA_W/8), burst==WRAP or reserved, or wlast does not fall exactly on beat len.
  - On an unsupported size or burst, all W beats are accepted and none are written.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. The AR handshake is in cycle N; rvalid=1 with beat 0 in cycle N+1. The RAM read is registered.
  - R_DATA: one beat per cycle while rready=1. rlast=1 only on beat arlen.
  - Index update follows the same INCR/FIXED rules as writes.
  - Unsupported size or burst: return arlen+1 beats with rdata=0 and rresp=SLVERR. Otherwise rresp=OKAY.
  - After the rlast handshake, arready=1 on the next cycle.
- Backpressure: when rvalid=1 and rready=0, rdata, rlast, rid and rresp hold stable. The RAM read address must not advance; prefetch only on handshake. bvalid holds until bready.
- Single beat: len=0 gives one beat, and that beat carries rlast or requires wlast.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-first).
- Reset mid-burst: in the next cycle both FSMs are idle and all valids are 0. The partial write is not rolled back.
- Outstanding transactions: one per direction. awready/arready stay 0 while the respective FSM is busy.

Test Plan:
- Write/read-back: AW addr=0x40, len=3, size=2, INCR, W data 0x11111111..0x44444444, wstrb=0xF. Require bresp=OKAY, bid=AW id. Then AR addr=0x40, len=3: require rdata 0x11111111..0x44444444, rlast on beat 3 only, first rvalid the cycle after the AR handshake.
- Byte strobes: write 0xAABBCCDD with wstrb=0x5 to a word preloaded with 0x00000000. Read back: require 0x00BB00DD.
- Read backpressure: len=7 read with rready toggled 1,0,0,1,... Require rdata stable while stalled, exactly 8 beats, no skipped or duplicated words.
- FIXED burst: len=2 write of 1,2,3 to 0x10. Require the word at 0x10 reads 3 and 0x14/0x18 are unchanged. Aliasing: a write at 0x1000 (DEPTH=1024, DATA_W=32) is readable at 0x0.
- Errors:
  - awsize=1: require bresp=SLVERR and memory unchanged.
  - Early wlast on beat 1 of len=3: require SLVERR.
  - arburst=WRAP, len=1: require 2 beats, rresp=SLVERR, rdata=0.
- Reset mid-burst: assert axi_rst during beat 2 of a len=7 read. Require rvalid=0 the next cycle and arready=1 the cycle after release. A new read returns correct data, and RAM contents are retained.
